// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like port between fetch and data, mapping kseg0/kseg1 and flagging uncached.
// Define ARB_RR_EN for round-robin arbitration; otherwise DATA_PRIO fixes the winner.
module mem_port_arbiter #(
    parameter bit INST_NOCACHE = 1'b0,
    parameter bit DATA_PRIO    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t      state, state_nxt;
    logic        grant, grant_data, done;
    logic        owner_data, wr_q, unc_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
`ifdef ARB_RR_EN
    logic        last_grant;
`endif
    function automatic logic [31:0] map_pa(input logic [31:0] va);
        return (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
    endfunction
    function automatic logic is_uncached(input logic [31:0] va);
        return (va[31:29] == 3'b101) || (va[31] && va[30:22] == 9'd0 && va[21:20] != 2'd0);
    endfunction
    always_comb begin
        grant = (state == IDLE) && (inst_req || data_req);
`ifdef ARB_RR_EN
        grant_data = (inst_req && data_req) ? !last_grant : data_req;
`else
        grant_data = (inst_req && data_req) ? DATA_PRIO : data_req;
`endif
        state_nxt = (state == IDLE) ? (grant ? ADDR : IDLE) :
                    (state == ADDR) ? (bus_addr_ok ? DATA : ADDR) :
                                      (bus_data_ok ? IDLE : DATA);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            unc_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_data <= grant_data;
                wr_q       <= grant_data && data_wr;
                size_q     <= grant_data ? data_size : 2'd2;
                addr_q     <= map_pa(grant_data ? data_addr : inst_addr);
                wdata_q    <= grant_data ? data_wdata : 32'd0;
                unc_q      <= grant_data ? is_uncached(data_addr) : (INST_NOCACHE && is_uncached(inst_addr));
            end
        end
    end
`ifdef ARB_RR_EN
    // 1 = data was granted last; starts as inst
    always_ff @(posedge clk) begin
        if (rst) last_grant <= 1'b0;
        else if (grant) last_grant <= grant_data;
    end
`endif
    // Outputs are forced low while reset is asserted so an abandoned transaction emits nothing
    assign done         = !rst && (state == DATA) && bus_data_ok;
    assign inst_addr_ok = !rst && grant && !grant_data;
    assign data_addr_ok = !rst && grant && grant_data;
    assign inst_data_ok = done && !owner_data;
    assign data_data_ok = done && owner_data;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;
    assign bus_req      = !rst && (state == ADDR);
    assign bus_wr       = !rst && wr_q;
    assign bus_size     = rst ? 2'd0 : size_q;
    assign bus_addr     = rst ? 32'd0 : addr_q;
    assign bus_wdata    = rst ? 32'd0 : wdata_q;
    assign bus_uncached = !rst && unc_q;
endmodule
